stream_chain_cipher: RTL

STREAM_CHAIN_CIPHER -- requirements
Module: stream_chain_cipher

---
 rtl/stream_chain_cipher_pkg.sv | 19 +
 rtl/stream_chain_cipher_chain_round.sv | 24 ++
 rtl/stream_chain_cipher.sv | 102 ++++++++++
 3 files changed

// File: rtl/stream_chain_cipher_pkg.sv
// stream_chain_cipher_pkg: FSM state encoding and width-generic rotate helpers.
package stream_chain_cipher_pkg;
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    function automatic logic [MAX_W-1:0] width_mask(input int w);
        return (MAX_W'(1) << w) - MAX_W'(1);
    endfunction

    // x must already be zero above bit w-1
    function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] x, input int w, input int r);
        return ((x << r) | (x >> (w - r))) & width_mask(w);
    endfunction

    function automatic logic [MAX_W-1:0] rotr(input logic [MAX_W-1:0] x, input int w, input int r);
        return ((x >> r) | (x << (w - r))) & width_mask(w);
    endfunction
endpackage

// File: rtl/stream_chain_cipher_chain_round.sv
// chain_round: one combinational cipher round, encrypt or decrypt against the running chain value.
module chain_round
    import stream_chain_cipher_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ROT = 3
) (
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] chain,
    input  logic [DATA_W-1:0] key,
    input  logic              mode,
    output logic [DATA_W-1:0] result
);
    logic [DATA_W-1:0] enc;
    logic [DATA_W-1:0] diff;
    logic [DATA_W-1:0] dec;

    always_comb begin
        enc = DATA_W'(rotl(MAX_W'(data ^ chain), DATA_W, ROT)) + key;
        diff = data - key;
        dec = DATA_W'(rotr(MAX_W'(diff), DATA_W, ROT)) ^ chain;
        result = mode ? dec : enc;
    end
endmodule

// File: rtl/stream_chain_cipher.sv
// stream_chain_cipher: framed chained stream cipher with a single registered output stage
// and a running comparison of the output frame against EXP.
module stream_chain_cipher #(
    parameter int DATA_W = 8,
    parameter int N = 42,
    parameter int ROT = 3,
    parameter logic [DATA_W-1:0] KEY = 8'h5A,
    parameter logic [DATA_W-1:0] IV = 8'h00,
    parameter logic [N*DATA_W-1:0] EXP = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done,
    output logic              match
);
    import stream_chain_cipher_pkg::*;

    localparam int IDX_W = $clog2(N + 1);

    state_t            state;
    logic              mode_q;
    logic              match_acc;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_c;
    logic [DATA_W-1:0] chain;
    logic [DATA_W-1:0] key;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] exp_word;
    logic              accept;
    logic              handoff;

    assign in_ready = (state == RUN) && (!out_valid || out_ready);
    assign accept = in_valid && in_ready;
    assign handoff = out_valid && out_ready;
    assign key = KEY + DATA_W'(idx);
    // word 0 sits in the most-significant slot of EXP
    assign idx_c = (idx < IDX_W'(N)) ? idx : '0;
    assign exp_word = EXP[DATA_W * (N - 1 - int'(idx_c)) +: DATA_W];

    chain_round #(.DATA_W(DATA_W), .ROT(ROT)) u_round (
        .data(in_data),
        .chain(chain),
        .key(key),
        .mode(mode_q),
        .result(result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mode_q <= 1'b0;
            match_acc <= 1'b0;
            idx <= '0;
            chain <= IV;
            out_data <= '0;
            out_valid <= 1'b0;
            done <= 1'b0;
            match <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= RUN;
                        mode_q <= mode;
                        idx <= '0;
                        chain <= IV;
                        match_acc <= 1'b1;
                        done <= 1'b0;
                        match <= 1'b0;
                    end
                end
                RUN: begin
                    out_valid <= accept || (out_valid && !out_ready);
                    if (accept) begin
                        out_data <= result;
                        chain <= mode_q ? in_data : result;
                        match_acc <= match_acc && (result == exp_word);
                        idx <= idx + 1'b1;
                        state <= (idx == IDX_W'(N - 1)) ? DRAIN : RUN;
                    end
                end
                DRAIN: begin
                    if (handoff) begin
                        out_valid <= 1'b0;
                        state <= DONE;
                        done <= 1'b1;
                        match <= match_acc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
